// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor: A - B - bin, one digit per clock, LSD first.
// Latency NDIG+1 edges start->done; start is ignored while busy or done.
module bcd_serial_sub #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              bin,
  output logic [4*NDIG-1:0] d,
  output logic              bout,
  output logic              err,
  output logic              busy,
  output logic              done
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [4*NDIG-1:0] a_l;
  logic [4*NDIG-1:0] b_l;
  logic [CW-1:0]     cnt;
  logic              borrow;

  logic [3:0] ad;
  logic [3:0] bd;
  logic [4:0] t;
  logic [3:0] dd;
  logic       bnext;
  logic       bad;
  logic       last;

  // Current digit difference; a negative 5-bit result is folded back by +10.
  always_comb begin
    ad    = a_l[cnt*4 +: 4];
    bd    = b_l[cnt*4 +: 4];
    t     = {1'b0, ad} - {1'b0, bd} - {4'b0000, borrow};
    bnext = t[4];
    dd    = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    bad   = (ad > 4'd9) || (bd > 4'd9);
    last  = (cnt == CW'(NDIG - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_l    <= '0;
      b_l    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_l    <= a;
            b_l    <= b;
            borrow <= bin;
            cnt    <= '0;
            d      <= '0;
            bout   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          d[cnt*4 +: 4] <= dd;
          borrow        <= bnext;
          cnt           <= cnt + 1'b1;
          if (bad) err <= 1'b1;
          if (last) begin
            bout  <= bnext;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Bench for bcd_serial_sub: directed and random operations against a decimal-arithmetic model.
module tb_bcd_serial_sub;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] d;
  logic         bout;
  logic         err;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  bcd_serial_sub #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: whole-number decimal subtraction, wrapped modulo 10^NDIG.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] ed, output logic eb);
    int m = 1;
    int diff;
    for (int i = 0; i < NDIG; i++) m = m * 10;
    diff = bcd2int(ma) - bcd2int(mb) - int'(mbin);
    eb   = (diff < 0);
    if (diff < 0) diff = diff + m;
    ed = int2bcd(diff);
  endtask

  function automatic logic [W-1:0] rnd_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Waits (bounded) for done; optionally disturbs inputs and start while running.
  task automatic wait_done(input logic disturb, output int edges);
    edges = 0;
    while (!done && edges < 40) begin
      if (disturb) begin
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                        input logic disturb);
    logic [W-1:0] ed;
    logic         eb;
    logic         ebad;
    int           edges;
    model(oa, ob, obin, ed, eb);
    ebad = has_bad(oa) || has_bad(ob);
    @(negedge clk);
    a = oa; b = ob; bin = obin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_after_start", 32'(done), 32'd0);
    wait_done(disturb, edges);
    chk("latency", 32'(edges), 32'(NDIG));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("err", 32'(err), 32'(ebad));
    if (!ebad) begin
      chk("d", 32'(d), 32'(ed));
      chk("bout", 32'(bout), 32'(eb));
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    if (!ebad) chk("d_held", 32'(d), 32'(ed));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] ed;
    logic         eb;
    int           edges;
    int           prev;
    int           pos;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(16'h0042, 16'h0017, 1'b0, 1'b0);
    run_op(16'h0017, 16'h0042, 1'b0, 1'b0);
    run_op(16'h1000, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(16'h9999, 16'h0000, 1'b0, 1'b0);
    run_op(16'h00A3, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0003, 1'b0, 1'b0);
    run_op(16'h0042, 16'h0017, 1'b0, 1'b1);

    for (int k = 0; k < 25; k++) begin
      ra = rnd_bcd();
      rb = rnd_bcd();
      if ($urandom_range(0, 5) == 0) begin
        pos = int'($urandom_range(0, NDIG - 1));
        ra[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      run_op(ra, rb, 1'($urandom), 1'($urandom));
    end

    // start held high: back-to-back acceptance
    ra = 16'h0931; rb = 16'h0478;
    model(ra, rb, 1'b1, ed, eb);
    @(negedge clk);
    a = ra; b = rb; bin = 1'b1; start = 1'b1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      edges = 0;
      while (!done && edges < 40) begin
        @(negedge clk);
        edges++;
      end
      if (k == 2) start = 1'b0;
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_d", 32'(d), 32'(ed));
      chk("b2b_bout", 32'(bout), 32'(eb));
      if (k > 0) chk("b2b_gap", 32'(cyc - prev), 32'(NDIG + 2));
      prev = cyc;
      @(negedge clk);
      chk("b2b_pulse", 32'(done), 32'd0);
    end

    // reset between digit 1 and digit 2
    @(negedge clk);
    a = 16'h0042; b = 16'h0017; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_d", 32'(d), 32'd0);
    chk("mid_rst_bout", 32'(bout), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0017, 16'h0042, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
